// File: rtl/zigbee_phase_to_iq.sv
// zigbee_phase_to_iq
// Converts a signed phase word into a fixed-amplitude I/Q pair with an
// iterative rotation-mode CORDIC (8 iterations, one per clock).
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   win        signed phase word, 5.625 deg/LSB
//   iValid     win valid; taken only while ready=1
//   ready      high while IDLE (a new word can be accepted)
//   ibb, qbb   signed I/Q result, held between strobes
//   oValid     one-cycle strobe marking a new ibb/qbb
//   dbg_state  current FSM state (IDLE=0, ROTATE=1, DONE=2)
//
// Handshake: a word is accepted on a rising edge where iValid=1 and ready=1.
// iValid is ignored whenever ready=0; there is no queuing. oValid is a
// single-cycle strobe with no back-pressure.
module zigbee_phase_to_iq #(
  parameter int IQ_SIZE   = 5,
  parameter int W_SIZE    = 6,
  parameter int AMPLITUDE = 15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic signed [W_SIZE-1:0]  win,
  input  logic                      iValid,
  output logic                      ready,
  output logic signed [IQ_SIZE-1:0] ibb,
  output logic signed [IQ_SIZE-1:0] qbb,
  output logic                      oValid,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Start vector pre-scaled by the CORDIC gain 0.60725, 6 fractional bits.
  localparam logic signed [11:0] X_INIT  = 12'((AMPLITUDE * 38864 + 500) / 1000);
  localparam logic signed [11:0] SAT_MAX = 12'(2 ** (IQ_SIZE - 1) - 1);

  state_t             state;
  logic [2:0]         iter;
  logic signed [11:0] x_r, y_r;
  logic signed [15:0] z_r;

  logic signed [15:0] z_load;
  logic signed [11:0] x_load;
  logic signed [11:0] x_sh, y_sh;
  logic signed [11:0] x_nxt, y_nxt;
  logic signed [15:0] z_nxt;
  logic signed [15:0] atan_i;
  logic signed [11:0] x_rnd, y_rnd;

  function automatic logic signed [15:0] atan_lut(input logic [2:0] i);
    case (i)
      3'd0:    atan_lut = 16'sd8192;
      3'd1:    atan_lut = 16'sd4836;
      3'd2:    atan_lut = 16'sd2555;
      3'd3:    atan_lut = 16'sd1297;
      3'd4:    atan_lut = 16'sd651;
      3'd5:    atan_lut = 16'sd326;
      3'd6:    atan_lut = 16'sd163;
      default: atan_lut = 16'sd81;
    endcase
  endfunction

  // Symmetric clamp: the most negative code is never produced.
  function automatic logic signed [IQ_SIZE-1:0] sat(input logic signed [11:0] v);
    if (v > SAT_MAX)       sat = IQ_SIZE'(SAT_MAX);
    else if (v < -SAT_MAX) sat = IQ_SIZE'(-SAT_MAX);
    else                   sat = IQ_SIZE'(v);
  endfunction

  always_comb begin
    z_load = 16'(win) <<< (16 - W_SIZE);
    x_load = X_INIT;
    // Phases in the outer half-plane start from -X and a 180-degree offset,
    // keeping the residual angle inside the CORDIC convergence range.
    if (win[W_SIZE-1] ^ win[W_SIZE-2]) begin
      x_load = -X_INIT;
      z_load = z_load ^ 16'sh8000;
    end

    atan_i = atan_lut(iter);
    x_sh   = x_r >>> iter;
    y_sh   = y_r >>> iter;
    if (!z_r[15]) begin
      x_nxt = x_r - y_sh;
      y_nxt = y_r + x_sh;
      z_nxt = z_r - atan_i;
    end else begin
      x_nxt = x_r + y_sh;
      y_nxt = y_r - x_sh;
      z_nxt = z_r + atan_i;
    end

    // Round to nearest integer by adding half an LSB before the shift.
    x_rnd = (x_r + 12'sd32) >>> 6;
    y_rnd = (y_r + 12'sd32) >>> 6;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      iter   <= 3'd0;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      ibb    <= '0;
      qbb    <= '0;
      oValid <= 1'b0;
    end else begin
      oValid <= 1'b0;
      case (state)
        IDLE: begin
          if (iValid) begin
            x_r   <= x_load;
            y_r   <= '0;
            z_r   <= z_load;
            iter  <= 3'd0;
            state <= ROTATE;
          end
        end
        ROTATE: begin
          x_r <= x_nxt;
          y_r <= y_nxt;
          z_r <= z_nxt;
          if (iter == 3'd7) begin
            state <= DONE;
          end else begin
            iter <= iter + 3'd1;
          end
        end
        DONE: begin
          ibb    <= sat(x_rnd);
          qbb    <= sat(y_rnd);
          oValid <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready     = (state == IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_zigbee_phase_to_iq.sv
// Directed bench for zigbee_phase_to_iq: reset state, accuracy points,
// latency/strobe width, busy-ignore, mid-computation reset, hold behaviour
// and a back-to-back sweep of all 64 phase codes.
module tb_zigbee_phase_to_iq;

  localparam real PI = 3.14159265358979;

  logic              clk;
  logic              reset_n;
  logic signed [5:0] win;
  logic              iValid;
  logic              ready;
  logic signed [4:0] ibb;
  logic signed [4:0] qbb;
  logic              oValid;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];

  zigbee_phase_to_iq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .win       (win),
    .iValid    (iValid),
    .ready     (ready),
    .ibb       (ibb),
    .qbb       (qbb),
    .oValid    (oValid),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- checkers ----------------
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int ideal);
    checks++;
    assert ((obs - ideal) <= 1 && (ideal - obs) <= 1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d+-1", tag, obs, ideal);
    end
  endtask

  task automatic check_range(input string tag, input int obs);
    checks++;
    assert (obs >= -15 && obs <= 15) else begin
      errors++;
      $error("FAIL %s: observed %0d expected within -15..15", tag, obs);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one word from IDLE and waits (bounded) for the strobe.
  // lat counts negedges after the accepting edge; 9 is the correct value.
  task automatic run_one(input logic signed [5:0] w, output int ib, output int qb,
                         output int lat);
    @(negedge clk);
    win    = w;
    iValid = 1'b1;
    @(negedge clk);
    iValid = 1'b0;
    lat = 0;
    while (!oValid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    ib = int'(ibb);
    qb = int'(qbb);
  endtask

  function automatic int ideal_cos(input int code);
    ideal_cos = int'(15.0 * $cos(real'(code) * 5.625 * PI / 180.0));
  endfunction

  function automatic int ideal_sin(input int code);
    ideal_sin = int'(15.0 * $sin(real'(code) * 5.625 * PI / 180.0));
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int ib, qb, lat;
    int pulses, sent, got, code, k;
    logic [5:0] pat;

    reset_n = 1'b0;
    win     = '0;
    iValid  = 1'b0;

    // Reset state
    #35;
    check("rst_ibb", int'(ibb), 0);
    check("rst_qbb", int'(qbb), 0);
    check("rst_ovalid", int'(oValid), 0);
    check("rst_ready", int'(ready), 1);
    check("rst_state", int'(dbg_state), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle with iValid=0 leaves everything alone
    repeat (3) @(negedge clk);
    check("idle_state", int'(dbg_state), 0);
    check("idle_ovalid", int'(oValid), 0);

    // Accuracy points
    run_one(6'sd0, ib, qb, lat);
    check("lat_w0", lat, 9);
    check_tol("i_w0", ib, 15);
    check_tol("q_w0", qb, 0);
    run_one(6'sd8, ib, qb, lat);
    check_tol("i_w8", ib, 11);
    check_tol("q_w8", qb, 11);
    run_one(6'sd16, ib, qb, lat);
    check_tol("i_w16", ib, 0);
    check_tol("q_w16", qb, 15);
    run_one(-6'sd16, ib, qb, lat);
    check_tol("i_wm16", ib, 0);
    check_tol("q_wm16", qb, -15);
    run_one(-6'sd32, ib, qb, lat);
    check_tol("i_wm32", ib, -15);
    check_tol("q_wm32", qb, 0);
    check_range("i_wm32_range", ib);

    // Hold between strobes
    repeat (4) @(negedge clk);
    check_tol("hold_i", int'(ibb), -15);
    check("hold_ovalid", int'(oValid), 0);

    // Latency / strobe width with win=4
    @(negedge clk);
    win    = 6'sd4;
    iValid = 1'b1;
    @(negedge clk);
    iValid = 1'b0;
    for (k = 0; k < 9; k++) begin
      check($sformatf("lat_ready_k%0d", k), int'(ready), 0);
      check($sformatf("lat_ovalid_k%0d", k), int'(oValid), 0);
      @(negedge clk);
    end
    check("lat_ovalid_k9", int'(oValid), 1);
    check("lat_ready_k9", int'(ready), 1);
    check_tol("i_w4", int'(ibb), 14);
    check_tol("q_w4", int'(qbb), 6);
    @(negedge clk);
    check("strobe_width", int'(oValid), 0);

    // Busy: second word presented before T3 must be ignored
    @(negedge clk);
    win    = 6'sd4;
    iValid = 1'b1;
    @(negedge clk);
    iValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    win    = 6'sd16;
    iValid = 1'b1;
    @(negedge clk);
    iValid = 1'b0;
    k = 3;
    while (!oValid && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("busy_lat", k, 9);
    check("busy_ready", int'(ready), 1);
    check_tol("busy_i", int'(ibb), 14);
    check_tol("busy_q", int'(qbb), 6);

    // Reset in the middle of ROTATE
    @(negedge clk);
    win    = 6'sd8;
    iValid = 1'b1;
    @(negedge clk);
    iValid = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mrst_ibb", int'(ibb), 0);
    check("mrst_qbb", int'(qbb), 0);
    check("mrst_ready", int'(ready), 1);
    check("mrst_state", int'(dbg_state), 0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (oValid) pulses++;
    end
    check("mrst_no_strobe", pulses, 0);
    run_one(6'sd0, ib, qb, lat);
    check("mrst_lat", lat, 9);
    check_tol("mrst_i", ib, 15);
    check_tol("mrst_q", qb, 0);

    // Back-to-back sweep of every code
    pulses = 0;
    sent   = 0;
    got    = 0;
    for (int cyc = 0; cyc < 700 && got < 64; cyc++) begin
      @(negedge clk);
      if (oValid) begin
        pulses++;
        if (exp_q.size() > 0) begin
          pat  = exp_q.pop_front();
          code = int'($signed(pat));
          check_tol($sformatf("sweep_i_%0d", code), int'(ibb), ideal_cos(code));
          check_tol($sformatf("sweep_q_%0d", code), int'(qbb), ideal_sin(code));
          check_range($sformatf("sweep_irange_%0d", code), int'(ibb));
          check_range($sformatf("sweep_qrange_%0d", code), int'(qbb));
          got++;
        end
      end
      if (ready && sent < 64) begin
        win    = 6'(sent);
        iValid = 1'b1;
        exp_q.push_back(6'(sent));
        sent++;
      end else if (sent == 64) begin
        iValid = 1'b0;
      end
    end
    iValid = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (oValid) pulses++;
    end
    check("sweep_pulses", pulses, 64);
    check("sweep_results", got, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
